// File: rtl/scan_sequencer_pkg.sv
// Shared types and helpers for the digit scan sequencer.
// State encodings are fixed so they match the decoder bring-up documentation.
package scan_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  // Next digit index, wrapping after the last populated digit.
  function automatic logic [2:0] idx_advance(input logic [2:0] idx, input logic [2:0] last_idx);
    return (idx >= last_idx) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// Digit-select bundle between the scan sequencer and the decoder / segment-data mux.
// master = sequencer side, slave = consumer side that supplies the scan enable.
interface scan_sequencer_if;
  logic en;
  logic a;
  logic b;
  logic c;
  logic blank;
  logic tick;
  logic frame;

  modport master (input en, output a, output b, output c, output blank, output tick, output frame);
  modport slave  (output en, input a, input b, input c, input blank, input tick, input frame);
endinterface

// File: rtl/scan_sequencer_counter.sv
// Dwell/blank cycle counter: synchronous clear wins over increment; at_term compares
// the registered count against the terminal value the owner supplies for its current state.
module scan_sequencer_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] term,
  output logic             at_term
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_term = (cnt_q == term);

endmodule

// File: rtl/scan_sequencer.sv
// Walks a 3-bit digit index 0..NUM_DIGITS-1 with a dwell of CLK_DIV cycles and an optional
// BLANK_CYC blanking gap per digit; tick/frame strobes mark index advance and wrap.
module scan_sequencer
  import scan_sequencer_pkg::*;
#(
  parameter int CLK_DIV    = 50000,
  parameter int BLANK_CYC  = 500,
  parameter int NUM_DIGITS = 8,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  scan_sequencer_if.master   bus
);

  localparam logic [2:0]       LAST_IDX   = 3'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] SHOW_TERM  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_TERM = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  state_t     state_d, state_q;
  logic [2:0] idx_d, idx_q;
  logic       blank_d, blank_q;
  logic       tick_d, tick_q;
  logic       frame_d, frame_q;

  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_at_term;
  logic [CNT_W-1:0] cnt_term;

  scan_sequencer_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .term    (cnt_term),
    .at_term (cnt_at_term)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    blank_d  = blank_q;
    tick_d   = 1'b0;
    frame_d  = 1'b0;
    cnt_clr  = 1'b1;
    cnt_inc  = 1'b0;
    cnt_term = (state_q == ST_BLANK) ? BLANK_TERM : SHOW_TERM;

    case (state_q)
      ST_IDLE: begin
        idx_d   = 3'd0;
        blank_d = 1'b1;
        if (bus.en) begin
          state_d = ST_SHOW;
          blank_d = 1'b0;
        end
      end
      ST_SHOW, ST_BLANK: begin
        // Dropping en beats a coincident terminal count: no strobe on the way out.
        if (!bus.en) begin
          state_d = ST_IDLE;
          idx_d   = 3'd0;
          blank_d = 1'b1;
        end else if (!cnt_at_term) begin
          cnt_clr = 1'b0;
          cnt_inc = 1'b1;
        end else if (state_q == ST_SHOW && BLANK_CYC > 0) begin
          state_d = ST_BLANK;
          blank_d = 1'b1;
        end else begin
          state_d = ST_SHOW;
          blank_d = 1'b0;
          idx_d   = idx_advance(idx_q, LAST_IDX);
          tick_d  = 1'b1;
          frame_d = (idx_q == LAST_IDX);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 3'd0;
        blank_d = 1'b1;
      end
    endcase

    // An index outside the populated digits would light a nonexistent line.
    if (idx_d > LAST_IDX) begin
      idx_d = 3'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      blank_q <= 1'b1;
      tick_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      blank_q <= blank_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
    end
  end

  assign bus.a     = idx_q[2];
  assign bus.b     = idx_q[1];
  assign bus.c     = idx_q[0];
  assign bus.blank = blank_q;
  assign bus.tick  = tick_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench: main instance (4/2/5) plus no-blank (4/0/5) and single-digit (4/2/1) builds.
// Observed vector per DUT is {a,b,c,blank,tick,frame}.
module tb_scan_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  scan_sequencer_if if_main ();
  scan_sequencer_if if_nb ();
  scan_sequencer_if if_one ();

  scan_sequencer #(.CLK_DIV(4), .BLANK_CYC(2), .NUM_DIGITS(5), .CNT_W(16)) u_main (
    .clk (clk), .rst (rst), .bus (if_main)
  );
  scan_sequencer #(.CLK_DIV(4), .BLANK_CYC(0), .NUM_DIGITS(5), .CNT_W(16)) u_nb (
    .clk (clk), .rst (rst), .bus (if_nb)
  );
  scan_sequencer #(.CLK_DIV(4), .BLANK_CYC(2), .NUM_DIGITS(1), .CNT_W(16)) u_one (
    .clk (clk), .rst (rst), .bus (if_one)
  );

  logic [5:0] o_main, o_nb, o_one;
  assign o_main = {if_main.a, if_main.b, if_main.c, if_main.blank, if_main.tick, if_main.frame};
  assign o_nb   = {if_nb.a, if_nb.b, if_nb.c, if_nb.blank, if_nb.tick, if_nb.frame};
  assign o_one  = {if_one.a, if_one.b, if_one.c, if_one.blank, if_one.tick, if_one.frame};

  typedef struct {
    logic       en;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [9];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [5:0] mk(input int idx, input bit bl, input bit tk, input bit fr);
    return {3'(idx), bl, tk, fr};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got abc_blank_tick_frame=%b required %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait on the main DUT: want_tick=1 waits for a tick onto idx, else for idx shown.
  task automatic wait_main(input logic [2:0] idx, input bit want_tick, input int limit, input string name);
    int n = 0;
    while (n < limit &&
           !(o_main[5:3] == idx && (want_tick ? o_main[1] == 1'b1 : o_main[2] == 1'b0))) begin
      step();
      n++;
    end
    n_tests++;
    if (n >= limit) begin
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles, got %b required idx %b", name, n, o_main, idx);
    end
  endtask

  initial begin
    int f1, f2, d, p, ex_idx;
    bit tk;

    tbl[0] = '{1'b0, mk(0, 1, 0, 0)};
    tbl[1] = '{1'b1, mk(0, 0, 0, 0)};
    tbl[2] = '{1'b1, mk(0, 0, 0, 0)};
    tbl[3] = '{1'b1, mk(0, 0, 0, 0)};
    tbl[4] = '{1'b1, mk(0, 0, 0, 0)};
    tbl[5] = '{1'b1, mk(0, 1, 0, 0)};
    tbl[6] = '{1'b1, mk(0, 1, 0, 0)};
    tbl[7] = '{1'b1, mk(1, 0, 1, 0)};
    tbl[8] = '{1'b1, mk(1, 0, 0, 0)};

    if_main.en = 1'b0;
    if_nb.en   = 1'b0;
    if_one.en  = 1'b0;
    rst        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_main", o_main, mk(0, 1, 0, 0));
    check("reset_nb", o_nb, mk(0, 1, 0, 0));
    check("reset_one", o_one, mk(0, 1, 0, 0));
    rst = 1'b0;

    // Start-up, first dwell, blanking gap and first advance.
    for (int i = 0; i < 9; i++) begin
      if_main.en = tbl[i].en;
      step();
      check($sformatf("vec%0d", i), o_main, tbl[i].exp);
    end

    // Two full frames: edge k counted from the enabling edge; first tick landed on k=6.
    f1 = -1;
    f2 = -1;
    for (int k = 8; k <= 61; k++) begin
      step();
      d      = k - 6;
      p      = d % 6;
      ex_idx = (1 + d / 6) % 5;
      tk     = (p == 0);
      check($sformatf("frame_run_k%0d", k), o_main, mk(ex_idx, p >= 4, tk, tk && ex_idx == 0));
      if (o_main[0]) begin
        if (f1 < 0) f1 = k;
        else if (f2 < 0) f2 = k;
      end
    end
    check_int("frame_period", f2 - f1, 30);

    // en dropped on the SHOW terminal cycle of digit 2.
    wait_main(3'd2, 1'b1, 40, "wait_idx2");
    for (int s = 1; s <= 3; s++) begin
      step();
      check($sformatf("show_idx2_s%0d", s), o_main, mk(2, 0, 0, 0));
    end
    if_main.en = 1'b0;
    step();
    check("en_drop_at_term", o_main, mk(0, 1, 0, 0));
    step();
    check("idle_hold", o_main, mk(0, 1, 0, 0));
    if_main.en = 1'b1;
    step();
    check("restart_show", o_main, mk(0, 0, 0, 0));
    repeat (4) step();
    check("restart_blank", o_main, mk(0, 1, 0, 0));
    step();
    step();
    check("restart_tick", o_main, mk(1, 0, 1, 0));

    // Asynchronous reset in the middle of a dwell on digit 3.
    wait_main(3'd3, 1'b0, 40, "wait_idx3");
    step();
    check("pre_rst_idx3", o_main, mk(3, 0, 0, 0));
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", o_main, mk(0, 1, 0, 0));
    step();
    step();
    check("rst_held", o_main, mk(0, 1, 0, 0));
    if_main.en = 1'b0;
    rst = 1'b0;

    // No-blank build: continuous display, tick every CLK_DIV cycles.
    if_nb.en = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      step();
      ex_idx = (k / 4) % 5;
      tk     = (k > 0) && (k % 4 == 0);
      check($sformatf("noblank_k%0d", k), o_nb, mk(ex_idx, 0, tk, tk && ex_idx == 0));
    end
    if_nb.en = 1'b0;
    step();
    check("noblank_idle", o_nb, mk(0, 1, 0, 0));

    // Single-digit build: every tick is a frame, index pinned at 0.
    if_one.en = 1'b1;
    for (int k = 0; k <= 24; k++) begin
      step();
      p  = k % 6;
      tk = (k > 0) && (p == 0);
      check($sformatf("onedig_k%0d", k), o_one, mk(0, p >= 4, tk, tk));
    end
    if_one.en = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
